// File: rtl/shift_add_mult8.sv
// Sequential unsigned 8x8 shift-and-add multiplier.
// One 16-bit carry-lookahead adder is shared across eight RUN iterations.
// The accumulator P drives the product output directly.
//
// Handshake semantics, both sides: a transfer happens on a rising clk edge
// where valid and ready are both high. in_ready depends only on state, so
// does not wait on in_valid. out_valid is held high with product stable
// until out_ready is seen. No output depends combinationally on any input.

// 4-bit carry-lookahead slice with group propagate/generate outputs.
module cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_pg,
  output logic       o_gg
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Internal carries are flattened sum-of-products, with no ripple.
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum = w_p ^ w_c;
  assign o_pg  = &w_p;
  assign o_gg  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

// 16-bit two-level carry-lookahead adder: four cla4 slices plus a group
// lookahead unit that forms each slice's carry-in directly.
module cla_add16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  logic [3:0] w_pg;
  logic [3:0] w_gg;
  logic [4:0] w_gc;

  // The second-level lookahead forms the group carries from the group P/G.
  assign w_gc[0] = i_cin;
  assign w_gc[1] = w_gg[0] | (w_pg[0] & i_cin);
  assign w_gc[2] = w_gg[1] | (w_pg[1] & w_gg[0]) | (w_pg[1] & w_pg[0] & i_cin);
  assign w_gc[3] = w_gg[2] | (w_pg[2] & w_gg[1]) | (w_pg[2] & w_pg[1] & w_gg[0])
                 | (w_pg[2] & w_pg[1] & w_pg[0] & i_cin);
  assign w_gc[4] = w_gg[3] | (w_pg[3] & w_gg[2]) | (w_pg[3] & w_pg[2] & w_gg[1])
                 | (w_pg[3] & w_pg[2] & w_pg[1] & w_gg[0])
                 | (w_pg[3] & w_pg[2] & w_pg[1] & w_pg[0] & i_cin);

  assign o_cout = w_gc[4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      cla4 u_cla4 (
        .i_a   (i_a[gi*4 +: 4]),
        .i_b   (i_b[gi*4 +: 4]),
        .i_cin (w_gc[gi]),
        .o_sum (o_sum[gi*4 +: 4]),
        .o_pg  (w_pg[gi]),
        .o_gg  (w_gg[gi])
      );
    end
  endgenerate
endmodule

// Multiplier top: IDLE -> RUN (eight iterations) -> DONE -> IDLE.
// WIDTH is fixed at 8 because the shared adder is fixed at 16 bits.
// CNT_W must equal log2(WIDTH).
module shift_add_mult8 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic [1:0]         dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2*WIDTH-1:0]   r_p;
  logic [2*WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]     r_q;
  logic [CNT_W-1:0]     r_count;

  logic                 w_accept;
  logic                 w_last_iter;
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_sum;
  logic                 w_unused_cout;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign w_addend    = r_q[0] ? r_m : '0;
  assign w_accept    = (r_state == S_IDLE) && in_valid;
  assign w_last_iter = (r_count == CNT_W'(WIDTH - 1));

  // Carry-out cannot be set: 255*255 fits in 16 bits.
  cla_add16 u_adder (
    .i_a    (r_p),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_unused_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and state-decoded handshake/status outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last_iter) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load on accept, then one shift-and-add step per RUN cycle.
  // P is left alone in DONE and IDLE, so the product holds until next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p     <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_p     <= '0;
      r_m     <= {{WIDTH{1'b0}}, a};
      r_q     <= b;
      r_count <= '0;
    end else if (r_state == S_RUN) begin
      r_p     <= w_sum;
      r_m     <= r_m << 1;
      r_q     <= r_q >> 1;
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign product   = r_p;
  assign dbg_state = r_state;
endmodule

// File: doc/shift_add_mult8.md
Name: shift_add_mult8

Overview:
- Sequential unsigned 8x8 shift-and-add multiplier that feeds and consumes the team's existing 16-bit CLA adder block.
- Each cycle it presents the partial-product accumulator and the shifted multiplicand to one adder instance, then registers the sum.
- Sits between operand-source logic and any result consumer.
- Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand width. Result is 2*WIDTH = 16 bits. Only 8 is supported, because the adder is fixed at 16 bits.
- CNT_W, 3, iteration counter width. Must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b valid
- in_ready  output  1  block can accept operands
- a  input  8  multiplicand, unsigned
- b  input  8  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  16  a*b, unsigned
- busy  output  1  high in RUN state

Behaviour:
- Reset is synchronous: rst is sampled on the clk rising edge and one clk, rst active-high. rst overrides all other inputs.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, internal M/Q/count=0.
- Internal registers:
  - P[15:0]: accumulator, drives product directly.
  - M[15:0]: multiplicand, zero-extended.
  - Q[7:0]: multiplier.
  - count[2:0]: iteration counter.
- Adder: one instance of the 16-bit CLA adder. Inputs are P and (Q[0] ? M : 16'h0), with cin=0. Its carry-out is ignored, since 255*255 < 2^16.
- IDLE state:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: P<=0, M<={8'h0,a}, Q<=b, count<=0, go to RUN.
- RUN state:
  - in_ready=0, busy=1.
  - Each edge: P<=adder sum, M<=M<<1, Q<=Q>>1, count<=count+1.
  - When count==7 at the edge, the 8th iteration completes and the state goes to DONE.
- DONE state:
  - out_valid=1, product=P, busy=0, in_ready=0.
  - On out_ready at an edge: go to IDLE, out_valid<=0.
  - product keeps its last value until the next accept clears P.
- Latency: operands accepted at edge E0 produce out_valid=1 after edge E8. The block always takes 8 RUN cycles, with no early termination even if Q becomes 0.
- Throughput: one product per 10 cycles minimum (accept, 8 RUN, DONE with out_ready=1). in_ready first returns high the cycle after the DONE handshake.
- in_valid is ignored outside IDLE. a and b are sampled only at the accept edge, so later changes have no effect.
- Backpressure: in DONE with out_ready=0, out_valid and product hold stable indefinitely.
- Reset mid-RUN or mid-DONE: the operation is aborted with no output, and all registers return to their reset values on that edge.
- out_ready in IDLE or RUN has no effect.
- All outputs are registered or decoded from state only. There are no combinational paths from any input to any output.

Test Plan:
- Basic: rst for 2 cycles, then a=13, b=11 with in_valid one cycle and out_ready=1. Required: out_valid rises exactly 8 cycles after accept with product=16'h008F (143), then in_ready=1 the following cycle.
- Max operands: a=255, b=255. Required: product=16'hFE01 (65025) with no wrap, and a=255, b=1 gives 16'h00FF.
- Zeros: a=0, b=200 and a=200, b=0. Required: product=0, and latency is still 8 cycles.
- Backpressure: a=7, b=9 with out_ready=0 for 5 cycles after out_valid. Required: out_valid and product=16'h003F held stable. The handshake completes on the edge where out_ready=1, and a new in_valid is accepted only after in_ready returns.
- Ignored input: during RUN, drive in_valid=1 with a=1, b=1 and toggle the original a/b. Required: no effect; the original a=20, b=30 gives product=16'h0258 (600).
- Reset mid-operation: assert rst at the 4th RUN cycle of a=100, b=100. Required: on the next edge state=IDLE, out_valid=0, product=0, in_ready=1. A fresh a=3, b=5 then gives 16'h000F.
